i2c_codec_responder: RTL and testbench

- I2C target (responder) that emulates the write-only WM8731-style codec control port; it is the far end of our I2C initializer.
- Oversamples SCL/SDA on i_clk and decodes 3-byte write transactions: device address, {reg[6:0], data[8]}, data[7:0].
- Drives ACK on SDA through an open-drain enable and stores writes into a 16-entry × 9-bit register file.
- Used in simulation and on-FPGA loopback to check initializer sequences without the real codec.

---
 rtl/i2c_codec_responder.sv | 182 ++++++++++++++++++
 tb/tb_i2c_codec_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_codec_responder.sv
// I2C write-only target emulating a WM8731-style codec control port.
// Decodes {dev addr, reg/data[8], data[7:0]} writes into a 16 x 9-bit register file.
module i2c_codec_responder #(
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    output logic       o_wr_valid,
    output logic [3:0] o_wr_addr,
    output logic [8:0] o_wr_data,
    input  logic [3:0] i_rd_addr,
    output logic [8:0] o_rd_data,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ACK_ADDR,
        S_BYTE1,
        S_ACK1,
        S_BYTE2,
        S_ACK2,
        S_IGNORE
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic       scl_prev, sda_prev;
    logic       scl, sda;
    logic       scl_rise, scl_fall, start_cond, stop_cond;
    logic [2:0] bit_cnt, bit_cnt_next;
    logic [7:0] shift, shift_next;
    logic [7:0] byte1, byte1_next;
    logic [7:0] full_byte;
    logic       oe_next, busy_next, commit;
    logic [3:0] reg_idx;
    logic [8:0] reg_data;
    logic [8:0] regs [16];

    // Synchronizers idle high so reset release never fakes a START.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], i_scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], i_sda};
            scl_prev <= scl;
            sda_prev <= sda;
        end
    end

    assign scl      = scl_sync[SYNC_STAGES-1];
    assign sda      = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl & ~scl_prev;
    assign scl_fall = ~scl & scl_prev;
    // SCL must be stable high across the sample, so a joint SCL/SDA change is plain data.
    assign start_cond = scl & scl_prev & sda_prev & ~sda;
    assign stop_cond  = scl & scl_prev & ~sda_prev & sda;

    assign full_byte = {shift[6:0], sda};
    assign reg_idx   = byte1[4:1];
    assign reg_data  = {byte1[0], shift};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            shift    <= '0;
            byte1    <= '0;
            o_sda_oe <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            state    <= state_next;
            bit_cnt  <= bit_cnt_next;
            shift    <= shift_next;
            byte1    <= byte1_next;
            o_sda_oe <= oe_next;
            o_busy   <= busy_next;
        end
    end

    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        shift_next   = shift;
        byte1_next   = byte1;
        oe_next      = o_sda_oe;
        busy_next    = o_busy;
        commit       = 1'b0;
        if (start_cond) begin
            state_next   = S_ADDR;
            bit_cnt_next = '0;
            shift_next   = '0;
            oe_next      = 1'b0;
            busy_next    = 1'b0;
        end else if (stop_cond) begin
            state_next = S_IDLE;
            oe_next    = 1'b0;
            busy_next  = 1'b0;
        end else begin
            case (state)
                S_ADDR, S_BYTE1, S_BYTE2: begin
                    if (scl_rise) begin
                        shift_next   = full_byte;
                        bit_cnt_next = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (state == S_ADDR) begin
                                state_next = (full_byte == {DEV_ADDR, 1'b0}) ? S_ACK_ADDR : S_IGNORE;
                            end else if (state == S_BYTE1) begin
                                byte1_next = full_byte;
                                state_next = S_ACK1;
                            end else begin
                                state_next = S_ACK2;
                            end
                        end
                    end
                end
                // First SCL fall after the 8th bit pulls SDA; the next one ends the ACK clock.
                S_ACK_ADDR, S_ACK1, S_ACK2: begin
                    if (scl_fall) begin
                        if (!o_sda_oe) begin
                            oe_next = 1'b1;
                            if (state == S_ACK_ADDR) begin
                                busy_next = 1'b1;
                            end
                        end else begin
                            oe_next      = 1'b0;
                            bit_cnt_next = '0;
                            case (state)
                                S_ACK_ADDR: state_next = S_BYTE1;
                                S_ACK1:     state_next = S_BYTE2;
                                default: begin
                                    state_next = S_IGNORE;
                                    commit     = 1'b1;
                                end
                            endcase
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // A write to register 15 is the codec reset: it wipes the whole file, itself included.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_wr_valid <= 1'b0;
            o_wr_addr  <= '0;
            o_wr_data  <= '0;
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else begin
            o_wr_valid <= 1'b0;
            if (commit && byte1[7:5] == 3'b000) begin
                o_wr_valid <= 1'b1;
                o_wr_addr  <= reg_idx;
                o_wr_data  <= reg_data;
                if (reg_idx == 4'hF) begin
                    for (int i = 0; i < 16; i++) begin
                        regs[i] <= '0;
                    end
                end else begin
                    regs[reg_idx] <= reg_data;
                end
            end
        end
    end

    assign o_rd_data = regs[i_rd_addr];

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Self-checking bench for i2c_codec_responder: bit-banged I2C controller,
// table of write transactions, commit scoreboard and a shadow register file.
module tb_i2c_codec_responder;

    logic       clk;
    logic       i_rst;
    logic       scl_m, sda_m;
    logic       sda_line;
    logic [3:0] rd_addr;
    logic       o_sda_oe, o_wr_valid, o_busy;
    logic [3:0] o_wr_addr;
    logic [8:0] o_wr_data, o_rd_data;

    typedef struct {
        logic [7:0] b0, b1, b2;
        logic [2:0] acks;
        logic       commit;
        logic [3:0] exp_addr;
        logic [8:0] exp_data;
    } vec_t;

    typedef struct packed {
        logic [3:0] addr;
        logic [8:0] data;
    } wr_t;

    vec_t       vecs [8];
    wr_t        exp_q [$];
    logic [8:0] model [16];
    logic [3:0] last_addr;
    logic [8:0] last_data;
    int         passed, total, oe_cycles;
    logic       prev_valid;

    assign sda_line = sda_m & ~o_sda_oe;

    i2c_codec_responder #(.DEV_ADDR(7'h1A), .SYNC_STAGES(2)) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_scl      (scl_m),
        .i_sda      (sda_line),
        .o_sda_oe   (o_sda_oe),
        .o_wr_valid (o_wr_valid),
        .o_wr_addr  (o_wr_addr),
        .o_wr_data  (o_wr_data),
        .i_rd_addr  (rd_addr),
        .o_rd_data  (o_rd_data),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Commit scoreboard: every o_wr_valid pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (o_wr_valid) begin
            if (prev_valid) checkOutput("wr_pulse_width", 32'd2, 32'd1);
            if (exp_q.size() == 0) begin
                checkOutput("wr_unexpected", {o_wr_addr, o_wr_data}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                checkOutput("wr_addr", o_wr_addr, e.addr);
                checkOutput("wr_data", o_wr_data, e.data);
            end
        end
        if (o_sda_oe) oe_cycles++;
        prev_valid = o_wr_valid;
    end

    task automatic quarter();
        repeat (4) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; quarter();
        scl_m = 1'b1; quarter();
        sda_m = 1'b0; quarter();
        scl_m = 1'b0; quarter();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; quarter();
        scl_m = 1'b1; quarter();
        sda_m = 1'b1; quarter();
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    quarter();
        scl_m = 1'b1; quarter(); quarter();
        scl_m = 1'b0; quarter();
    endtask

    // Ninth clock: controller releases SDA and samples the target's ACK while SCL is high.
    task automatic ack_clock(output logic ack);
        sda_m = 1'b1; quarter();
        scl_m = 1'b1; quarter();
        ack = ~sda_line;
        quarter();
        scl_m = 1'b0; quarter();
        checkOutput("sda_released", o_sda_oe, 1'b0);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        ack_clock(ack);
    endtask

    task automatic model_write(input logic [3:0] a, input logic [8:0] d);
        exp_q.push_back('{addr: a, data: d});
        last_addr = a;
        last_data = d;
        if (a == 4'hF) begin
            for (int i = 0; i < 16; i++) model[i] = '0;
        end else begin
            model[a] = d;
        end
    endtask

    task automatic check_regs();
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            #1;
            checkOutput($sformatf("rd_data[%0d]", i), o_rd_data, model[i]);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        logic a0, a1, a2;
        int   oe_before;
        oe_before = oe_cycles;
        i2c_start();
        write_byte(v.b0, a0);
        checkOutput("ack_addr", a0, v.acks[2]);
        checkOutput("busy_after_addr", o_busy, v.acks[2]);
        write_byte(v.b1, a1);
        checkOutput("ack_byte1", a1, v.acks[1]);
        if (v.commit) model_write(v.exp_addr, v.exp_data);
        write_byte(v.b2, a2);
        checkOutput("ack_byte2", a2, v.acks[0]);
        i2c_stop();
        quarter();
        checkOutput("busy_after_stop", o_busy, 1'b0);
        checkOutput("pending_writes", exp_q.size(), 0);
        checkOutput("wr_addr_hold", o_wr_addr, last_addr);
        checkOutput("wr_data_hold", o_wr_data, last_data);
        if (v.acks == 3'b000) checkOutput("oe_silent", oe_cycles - oe_before, 0);
    endtask

    initial begin
        logic ack;
        int   oe_before;
        clk = 1'b0; i_rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; rd_addr = '0;
        passed = 0; total = 0; oe_cycles = 0; prev_valid = 1'b0;
        last_addr = '0; last_data = '0;
        for (int i = 0; i < 16; i++) model[i] = '0;

        vecs[0] = '{8'h34, 8'h0E, 8'h42, 3'b111, 1'b1, 4'h7, 9'h042};
        vecs[1] = '{8'h36, 8'h0E, 8'h42, 3'b000, 1'b0, 4'h0, 9'h000};
        vecs[2] = '{8'h34, 8'h04, 8'hAB, 3'b111, 1'b1, 4'h2, 9'h0AB};
        vecs[3] = '{8'h34, 8'h40, 8'h55, 3'b111, 1'b0, 4'h0, 9'h000};
        vecs[4] = '{8'h34, 8'h1E, 8'h00, 3'b111, 1'b1, 4'hF, 9'h000};
        vecs[5] = '{8'h34, 8'h0F, 8'h99, 3'b111, 1'b1, 4'h7, 9'h199};
        vecs[6] = '{8'h34, 8'h00, 8'h01, 3'b111, 1'b1, 4'h0, 9'h001};
        vecs[7] = '{8'h34, 8'h1D, 8'hFF, 3'b111, 1'b1, 4'hE, 9'h1FF};

        repeat (3) @(negedge clk);
        checkOutput("rst_sda_oe", o_sda_oe, 1'b0);
        checkOutput("rst_wr_valid", o_wr_valid, 1'b0);
        checkOutput("rst_wr_addr", o_wr_addr, 4'h0);
        checkOutput("rst_wr_data", o_wr_data, 9'h000);
        checkOutput("rst_busy", o_busy, 1'b0);
        check_regs();
        i_rst = 1'b0;
        quarter();

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            check_regs();
        end

        // Read request to our own address is NACKed and ignored.
        oe_before = oe_cycles;
        i2c_start();
        write_byte(8'h35, ack);
        checkOutput("read_req_nack", ack, 1'b0);
        checkOutput("read_req_busy", o_busy, 1'b0);
        write_byte(8'h0E, ack);
        checkOutput("read_req_byte_nack", ack, 1'b0);
        i2c_stop();
        checkOutput("read_req_oe_silent", oe_cycles - oe_before, 0);

        // STOP before byte2 drops the write; repeated START restarts cleanly.
        i2c_start();
        write_byte(8'h34, ack);
        checkOutput("partial_ack_addr", ack, 1'b1);
        write_byte(8'h0E, ack);
        checkOutput("partial_ack1", ack, 1'b1);
        i2c_stop();
        quarter();
        checkOutput("partial_busy", o_busy, 1'b0);
        i2c_start();
        write_byte(8'h34, ack);
        write_byte(8'h0E, ack);
        i2c_start();
        checkOutput("rstart_busy", o_busy, 1'b0);
        write_byte(8'h34, ack);
        checkOutput("rstart_ack_addr", ack, 1'b1);
        model_write(4'h4, 9'h123);
        write_byte(8'h09, ack);
        write_byte(8'h23, ack);
        checkOutput("rstart_ack2", ack, 1'b1);
        i2c_stop();
        quarter();
        checkOutput("rstart_pending", exp_q.size(), 0);
        check_regs();

        // Reset in the middle of byte2 of a valid write.
        i2c_start();
        write_byte(8'h34, ack);
        write_byte(8'h0A, ack);
        for (int i = 0; i < 4; i++) write_bit(1'b1);
        checkOutput("pre_rst_busy", o_busy, 1'b1);
        i_rst = 1'b1;
        #1;
        checkOutput("mid_rst_sda_oe", o_sda_oe, 1'b0);
        checkOutput("mid_rst_busy", o_busy, 1'b0);
        checkOutput("mid_rst_wr_addr", o_wr_addr, 4'h0);
        checkOutput("mid_rst_wr_data", o_wr_data, 9'h000);
        for (int i = 0; i < 16; i++) model[i] = '0;
        last_addr = '0; last_data = '0;
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        for (int i = 0; i < 4; i++) write_bit(1'b0);
        ack_clock(ack);
        checkOutput("post_rst_nack", ack, 1'b0);
        i2c_stop();
        quarter();
        checkOutput("post_rst_wr_valid", o_wr_valid, 1'b0);
        check_regs();

        applyStimulus(vecs[0]);
        check_regs();

        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
